// File: rtl/usr_shift.sv
// Universal shift register: parallel load, manual single-step shift,
// and counted burst shifts with busy/done handshake.
module usr_shift #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             sft,
  input  logic             start,
  input  logic [CW-1:0]    nsft,
  input  logic             dir,
  input  logic             rot,
  input  logic             sin,
  input  logic [WIDTH-1:0] db,
  output logic [WIDTH-1:0] qb,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } st_t;

  st_t             st;
  logic [CW-1:0]   cnt;
  logic            fill;
  logic [WIDTH-1:0] nxt;

  assign sout = dir ? qb[WIDTH-1] : qb[0];
  assign fill = rot ? sout : sin;
  assign nxt  = dir ? {qb[WIDTH-2:0], fill}
                    : {fill, qb[WIDTH-1:1]};

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st   <= IDLE;
      cnt  <= '0;
      qb   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          // Arms are made disjoint so load > start > sft.
          unique case (1'b1)
            load: qb <= db;
            (!load && start): begin
              if (nsft == '0) begin
                st   <= DONE;
                done <= 1'b1;
              end else begin
                st   <= SHIFT;
                cnt  <= nsft;
                busy <= 1'b1;
              end
            end
            (!load && !start && sft): qb <= nxt;
            default: ;
          endcase
        end
        SHIFT: begin
          if (load) begin
            qb   <= db;
            st   <= IDLE;
            cnt  <= '0;
            busy <= 1'b0;
          end else begin
            qb  <= nxt;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              st   <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        DONE: begin
          st   <= IDLE;
          done <= 1'b0;
          if (load) qb <= db;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usr_shift.sv
// Scoreboard bench for usr_shift: directed scenarios plus random
// traffic against a cycle-level behavioural model.
module tb_usr_shift;

  logic       clk = 1'b0;
  logic       clr;
  logic       load, sft, start;
  logic [3:0] nsft;
  logic       dir, rot, sin;
  logic [7:0] db;
  logic [7:0] qb;
  logic       sout, busy, done;

  usr_shift #(.WIDTH(8), .CW(4)) dut (
    .clk(clk), .clr(clr), .load(load), .sft(sft),
    .start(start), .nsft(nsft), .dir(dir), .rot(rot),
    .sin(sin), .db(db), .qb(qb), .sout(sout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] q;
    logic       b;
    logic       d;
  } exp_t;

  exp_t sb[$];
  int   edges  = 0;
  int   checks = 0;
  int   errors = 0;

  // model state: value, shifts left in burst, done pending
  int mq   = 0;
  int mrem = 0;
  bit mdn  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int mshift(input int v, input bit d,
                                input bit r, input bit s);
    int f;
    if (d) begin
      f = r ? ((v >> 7) & 1) : int'(s);
      return ((v * 2) % 256) + f;
    end
    f = r ? (v & 1) : int'(s);
    return (v / 2) + f * 128;
  endfunction

  function automatic void mstep();
    if (mrem > 0) begin
      if (load) mrem = 0;
      if (load) mq = int'(db);
      else begin
        mq = mshift(mq, dir, rot, sin);
        mrem = mrem - 1;
        if (mrem == 0) mdn = 1;
      end
    end else if (mdn) begin
      mdn = 0;
      if (load) mq = int'(db);
    end else if (load) mq = int'(db);
    else if (start) begin
      if (nsft == 0) mdn = 1;
      else mrem = int'(nsft);
    end else if (sft) mq = mshift(mq, dir, rot, sin);
  endfunction

  always @(posedge clk) edges++;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= edges) begin
      exp_t e;
      e = sb.pop_front();
      chk("sb_qb", int'(qb), int'(e.q));
      chk("sb_busy", int'(busy), int'(e.b));
      chk("sb_done", int'(done), int'(e.d));
    end
  end

  task automatic step(input bit l, input bit st, input bit sf,
                      input int n, input bit d, input bit r,
                      input bit s, input int dv);
    exp_t e;
    load = l; start = st; sft = sf; nsft = 4'(n);
    dir = d; rot = r; sin = s; db = 8'(dv);
    mstep();
    e.cyc = edges + 1;
    e.q = 8'(mq);
    e.b = (mrem > 0);
    e.d = mdn;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, dir, rot, sin, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 0; load = 0; sft = 0; start = 0; nsft = 0;
    dir = 0; rot = 0; sin = 0; db = 0;
    #3;
    chk("rst_qb", int'(qb), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    #9 clr = 1;
    @(posedge clk);
    #1;

    // load then one manual right shift filling 1
    step(1, 0, 0, 0, 0, 0, 1, 8'hB5);
    chk("load_qb", int'(qb), 8'hB5);
    dir = 0; rot = 0; sin = 1;
    #1;
    chk("sout_r", int'(sout), 1);
    step(0, 0, 1, 0, 0, 0, 1, 0);
    chk("sft_qb", int'(qb), 8'hDA);

    // burst of 3 left rotates
    step(1, 0, 0, 0, 1, 1, 0, 8'hB5);
    step(0, 1, 0, 3, 1, 1, 0, 0);
    chk("b3_busy0", int'(busy), 1);
    chk("b3_q0", int'(qb), 8'hB5);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    chk("b3_q1", int'(qb), 8'h6B);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    chk("b3_q2", int'(qb), 8'hD6);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    chk("b3_q3", int'(qb), 8'hAD);
    chk("b3_done", int'(done), 1);
    chk("b3_busy3", int'(busy), 0);
    idle(1);
    chk("b3_done_end", int'(done), 0);

    // zero-length burst
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("z_done", int'(done), 1);
    chk("z_busy", int'(busy), 0);
    chk("z_qb", int'(qb), 8'hAD);
    idle(2);

    // load aborts burst on 4th busy cycle
    step(0, 1, 0, 10, 0, 0, 1, 0);
    idle(3);
    chk("ab_busy4", int'(busy), 1);
    step(1, 0, 0, 0, 0, 0, 1, 8'h3C);
    chk("ab_qb", int'(qb), 8'h3C);
    chk("ab_busy", int'(busy), 0);
    idle(3);

    // async clear mid-burst
    step(0, 1, 0, 6, 1, 0, 1, 0);
    idle(2);
    load = 0; start = 0; sft = 0;
    #2 clr = 0;
    #1;
    chk("ac_qb", int'(qb), 0);
    chk("ac_busy", int'(busy), 0);
    chk("ac_done", int'(done), 0);
    sb.delete();
    mq = 0; mrem = 0; mdn = 0;
    @(posedge clk);
    #2 clr = 1;
    @(posedge clk);
    #1;

    // random traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 99) < 6, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 4, $urandom_range(0, 7),
           1'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 255)));
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/usr_shift.md
USR_SHIFT -- requirements
Module: usr_shift

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data register width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CW, default 4, giving the burst shift-count width in bits (legal range 1..8).
REQ-003 Port clk SHALL be an input, width 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port clr SHALL be an input, width 1, the reset; it SHALL be asynchronous and active-low.
REQ-005 Port load SHALL be an input, width 1, the parallel load request.
REQ-006 Port sft SHALL be an input, width 1, the single-step manual shift request.
REQ-007 Port start SHALL be an input, width 1, the burst shift request.
REQ-008 Port nsft SHALL be an input, width CW, the burst shift count, sampled on start.
REQ-009 Port dir SHALL be an input, width 1, the shift direction: 0 = right (toward LSB), 1 = left (toward MSB).
REQ-010 Port rot SHALL be an input, width 1, the rotate select: 1 = vacated bit takes the bit shifted out, 0 = vacated bit takes sin.
REQ-011 Port sin SHALL be an input, width 1, the serial fill bit.
REQ-012 Port db SHALL be an input, width WIDTH, the parallel load data.
REQ-013 Port qb SHALL be an output, width WIDTH, the registered data.
REQ-014 Port sout SHALL be an output, width 1, the bit that the next shift removes: qb[0] if dir=0, qb[WIDTH-1] if dir=1 (combinational).
REQ-015 Port busy SHALL be an output, width 1, high while a burst is in progress.
REQ-016 Port done SHALL be an output, width 1, a one-cycle pulse at burst completion.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT and DONE; busy SHALL be high only in SHIFT, and done SHALL be high only in DONE.
REQ-018 In IDLE, priority SHALL be load > start > sft; only the highest-priority active request SHALL act on an edge.
REQ-019 On load, qb SHALL take db on that edge and the state SHALL remain (or become) IDLE.
REQ-020 On sft in IDLE, qb SHALL perform exactly one shift per edge while sft is high, using the current dir, rot and sin.
REQ-021 Shift right SHALL be: qb <= {fill, qb[WIDTH-1:1]}; shift left SHALL be: qb <= {qb[WIDTH-2:0], fill}; fill SHALL be sout if rot=1, and sin otherwise.
REQ-022 On start in IDLE with nsft=N>0, the FSM SHALL latch N into an internal remaining counter and enter SHIFT; qb SHALL be unchanged on that edge.
REQ-023 In SHIFT, each edge SHALL perform one shift (dir, rot and sin sampled live) and decrement the counter; the edge performing the Nth shift SHALL enter DONE.
REQ-024 A burst SHALL therefore give busy for exactly N cycles, the Nth shift visible on qb when done rises, and done for exactly 1 cycle, after which the FSM SHALL return to IDLE.
REQ-025 start with nsft=0 SHALL go IDLE->DONE directly, with no shift and busy never asserted.
REQ-026 A load in SHIFT or DONE SHALL load db, abort the burst and go to IDLE; done SHALL NOT pulse for an aborted burst.
REQ-027 start and sft SHALL be ignored in SHIFT and DONE; a held start SHALL retrigger only once back in IDLE.
REQ-028 With load, start and sft all low in IDLE, qb SHALL hold.

Reset
REQ-029 While clr=0, the block SHALL immediately (without a clock) set qb=0, the state to IDLE, the counter to 0, and busy=0 and done=0, aborting any burst.
REQ-030 After clr deasserts, the first active edge SHALL obey the IDLE rules normally.

Verification (WIDTH=8, CW=4)
REQ-031 The bench SHALL cover: clr=0 then release, load=1 with db=8'hB5 -> qb=8'hB5 after one edge.
REQ-032 The bench SHALL cover: qb=8'hB5, sft=1 for one edge, dir=0, rot=0, sin=1 -> sout=1 before the edge, qb=8'hDA after.
REQ-033 The bench SHALL cover: qb=8'hB5, start with nsft=3, dir=1, rot=1 -> busy high for 3 cycles with qb stepping 6B, D6, AD; done pulses for 1 cycle with qb=8'hAD; then IDLE.
REQ-034 The bench SHALL cover: start with nsft=0 -> done high for exactly 1 cycle, busy stays 0, qb unchanged.
REQ-035 The bench SHALL cover: a burst with nsft=10, load=1 with db=8'h3C on the 4th busy cycle -> qb=8'h3C, busy=0 next cycle, no done pulse.
REQ-036 The bench SHALL cover: clr pulled low mid-burst between clock edges -> qb=0, busy=0 and done=0 immediately, before the next edge.
